// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bus between the MEM-stage LSU and the data memory.
//
// Handshake: a request transfers on a rising edge where dmem_req_valid and
// dmem_req_ready are both 1. While valid is 1 and ready is 0 the master holds
// addr/we/be/wdata stable and keeps valid asserted. A response (read data or
// write ack) is a single cycle with dmem_rsp_valid=1. There is no rsp_ready.
// dmem_rsp_err is meaningful only when dmem_rsp_valid is 1.
interface mem_stage_lsu_if;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [31:0] dmem_addr;
   logic        dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rdata;
   logic        dmem_rsp_err;

   modport master (
      output dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
      input  dmem_req_ready, dmem_rsp_valid, dmem_rdata, dmem_rsp_err
   );

   modport slave (
      input  dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
      output dmem_req_ready, dmem_rsp_valid, dmem_rdata, dmem_rsp_err
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one data-memory access per MEM-stage
// load/store, stalls the pipeline until it completes, and returns extended load
// data plus misaligned/access-fault pulses for the trap logic.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          alu_result_mem,
   input  logic [31:0]          rs2_data_mem,
   input  logic [2:0]           funct3_mem,
   input  logic                 mem_read_mem,
   input  logic                 mem_write_mem,
   mem_stage_lsu_if.master      dmem,
   output logic                 mem_stall,
   output logic [31:0]          load_data_mem,
   output logic                 load_valid,
   output logic                 misaligned,
   output logic                 access_fault,
   output logic [31:0]          fault_addr,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [7:0]  wait_cnt;
   logic [31:0] addr_q;
   logic [2:0]  f3_q;

   logic        access;
   logic        illegal_f3;
   logic        misalign_in;
   logic [3:0]  be_in;
   logic [31:0] wdata_in;
   logic        timeout;
   logic [31:0] lane_shift;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   assign access    = mem_read_mem | mem_write_mem;
   assign timeout   = (wait_cnt == TIMEOUT_LAST);
   assign state_dbg = state;

   // Decode the incoming access: legality, alignment, byte enables, lane-replicated store data.
   always_comb begin
      illegal_f3  = (funct3_mem == 3'b011) || (funct3_mem[2:1] == 2'b11);
      misalign_in = illegal_f3;
      be_in       = 4'b1111;
      wdata_in    = rs2_data_mem;
      case (funct3_mem[1:0])
         2'b00: begin
            be_in    = 4'b0001 << alu_result_mem[1:0];
            wdata_in = {4{rs2_data_mem[7:0]}};
         end
         2'b01: begin
            be_in       = alu_result_mem[1] ? 4'b1100 : 4'b0011;
            wdata_in    = {2{rs2_data_mem[15:0]}};
            misalign_in = illegal_f3 | alu_result_mem[0];
         end
         default: begin
            misalign_in = illegal_f3 | (alu_result_mem[1:0] != 2'b00);
         end
      endcase
   end

   // Pick the addressed lane of the read word and sign/zero-extend it.
   always_comb begin
      lane_shift = dmem.dmem_rdata >> {addr_q[1:0], 3'b000};
      byte_sel   = lane_shift[7:0];
      half_sel   = addr_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_ext = {24'h0, byte_sel};
         3'b101:  load_ext = {16'h0, half_sel};
         default: load_ext = dmem.dmem_rdata;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and pipeline stall.
   always_comb begin
      state_nxt = state;
      mem_stall = 1'b0;
      case (state)
         S_IDLE: begin
            if (access) begin
               mem_stall = 1'b1;
               state_nxt = misalign_in ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            mem_stall = 1'b1;
            if (dmem.dmem_req_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            mem_stall = 1'b1;
            if (dmem.dmem_rsp_valid || timeout) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request payload, wait counter, load result and the one-cycle result pulses.
   // Pulses are set on the edge that enters DONE so they are high for exactly the DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         dmem.dmem_req_valid <= 1'b0;
         dmem.dmem_addr      <= 32'h0;
         dmem.dmem_we        <= 1'b0;
         dmem.dmem_be        <= 4'h0;
         dmem.dmem_wdata     <= 32'h0;
         wait_cnt            <= 8'h0;
         addr_q              <= 32'h0;
         f3_q                <= 3'b000;
         load_data_mem       <= 32'h0;
         load_valid          <= 1'b0;
         misaligned          <= 1'b0;
         access_fault        <= 1'b0;
         fault_addr          <= 32'h0;
      end else begin
         load_valid   <= 1'b0;
         misaligned   <= 1'b0;
         access_fault <= 1'b0;
         case (state)
            S_IDLE: begin
               wait_cnt <= 8'h0;
               if (access) begin
                  addr_q          <= alu_result_mem;
                  f3_q            <= funct3_mem;
                  dmem.dmem_addr  <= {alu_result_mem[31:2], 2'b00};
                  dmem.dmem_we    <= mem_write_mem;
                  dmem.dmem_be    <= be_in;
                  dmem.dmem_wdata <= wdata_in;
                  if (misalign_in) begin
                     misaligned <= 1'b1;
                     fault_addr <= alu_result_mem;
                  end else begin
                     dmem.dmem_req_valid <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (dmem.dmem_req_ready) dmem.dmem_req_valid <= 1'b0;
            end
            S_WAIT: begin
               if (dmem.dmem_rsp_valid) begin
                  if (dmem.dmem_rsp_err) begin
                     access_fault <= 1'b1;
                     fault_addr   <= addr_q;
                  end else if (!dmem.dmem_we) begin
                     load_valid    <= 1'b1;
                     load_data_mem <= load_ext;
                  end
               end else if (timeout) begin
                  access_fault <= 1'b1;
                  fault_addr   <= addr_q;
               end else begin
                  wait_cnt <= wait_cnt + 8'h1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a vector table of single accesses with
// hand-computed bus payloads and load results, plus hand-written sequences for
// back-pressure, timeout, bus error and reset in the middle of an access.
module tb_mem_stage_lsu;

   logic        clk;
   logic        rst;
   logic [31:0] alu_result_mem;
   logic [31:0] rs2_data_mem;
   logic [2:0]  funct3_mem;
   logic        mem_read_mem;
   logic        mem_write_mem;
   logic        mem_stall;
   logic [31:0] load_data_mem;
   logic        load_valid;
   logic        misaligned;
   logic        access_fault;
   logic [31:0] fault_addr;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   mem_stage_lsu_if bus ();

   mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .alu_result_mem (alu_result_mem),
      .rs2_data_mem   (rs2_data_mem),
      .funct3_mem     (funct3_mem),
      .mem_read_mem   (mem_read_mem),
      .mem_write_mem  (mem_write_mem),
      .dmem           (bus.master),
      .mem_stall      (mem_stall),
      .load_data_mem  (load_data_mem),
      .load_valid     (load_valid),
      .misaligned     (misaligned),
      .access_fault   (access_fault),
      .fault_addr     (fault_addr),
      .state_dbg      (state_dbg)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] rs2;
      logic [2:0]  f3;
      logic        rd;
      logic        wr;
      logic [31:0] rdata;
      logic [31:0] exp_addr;
      logic        exp_we;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic        exp_mis;
      logic        exp_lv;
      logic [31:0] exp_ld;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_read_mem   = 1'b0;
      mem_write_mem  = 1'b0;
      alu_result_mem = 32'h0;
      rs2_data_mem   = 32'h0;
      funct3_mem     = 3'b000;
   endtask

   task automatic start_access(input logic [31:0] addr, input logic [31:0] rs2,
                               input logic [2:0] f3, input logic rd, input logic wr);
      alu_result_mem = addr;
      rs2_data_mem   = rs2;
      funct3_mem     = f3;
      mem_read_mem   = rd;
      mem_write_mem  = wr;
   endtask

   // One full access from the table: accept, request, response, DONE, back to IDLE.
   task automatic run_vec(input int idx, input vec_t v);
      string p;
      p = $sformatf("v%0d", idx);
      bus.dmem_req_ready = 1'b0;
      bus.dmem_rsp_valid = 1'b0;
      bus.dmem_rsp_err   = 1'b0;
      start_access(v.addr, v.rs2, v.f3, v.rd, v.wr);
      #1;
      check({p, "_stall_accept"}, {31'h0, mem_stall}, 32'h1);
      step();
      if (v.exp_mis) begin
         clear_inputs();
         #1;
         check({p, "_misaligned"}, {31'h0, misaligned}, 32'h1);
         check({p, "_fault_addr"}, fault_addr, v.addr);
         check({p, "_no_req"}, {31'h0, bus.dmem_req_valid}, 32'h0);
         check({p, "_stall_done"}, {31'h0, mem_stall}, 32'h0);
         check({p, "_no_load_valid"}, {31'h0, load_valid}, 32'h0);
      end else begin
         bus.dmem_req_ready = 1'b1;
         #1;
         check({p, "_req_valid"}, {31'h0, bus.dmem_req_valid}, 32'h1);
         check({p, "_addr"}, bus.dmem_addr, v.exp_addr);
         check({p, "_we"}, {31'h0, bus.dmem_we}, {31'h0, v.exp_we});
         check({p, "_be"}, {28'h0, bus.dmem_be}, {28'h0, v.exp_be});
         check({p, "_wdata"}, bus.dmem_wdata, v.exp_wdata);
         check({p, "_stall_req"}, {31'h0, mem_stall}, 32'h1);
         step();
         bus.dmem_req_ready = 1'b0;
         bus.dmem_rsp_valid = 1'b1;
         bus.dmem_rdata     = v.rdata;
         #1;
         check({p, "_req_dropped"}, {31'h0, bus.dmem_req_valid}, 32'h0);
         check({p, "_stall_wait"}, {31'h0, mem_stall}, 32'h1);
         step();
         bus.dmem_rsp_valid = 1'b0;
         clear_inputs();
         #1;
         check({p, "_stall_done"}, {31'h0, mem_stall}, 32'h0);
         check({p, "_load_valid"}, {31'h0, load_valid}, {31'h0, v.exp_lv});
         check({p, "_no_fault"}, {30'h0, misaligned, access_fault}, 32'h0);
         if (v.exp_lv) check({p, "_load_data"}, load_data_mem, v.exp_ld);
      end
      step();
      check({p, "_back_idle"}, {30'h0, state_dbg}, 32'h0);
      check({p, "_pulses_low"}, {29'h0, load_valid, misaligned, access_fault}, 32'h0);
   endtask

   initial begin
      // addr rs2 f3 rd wr rdata | exp_addr we be wdata mis lv ld
      vecs[0]  = '{32'h100, 32'h0,        3'b010, 1'b1, 1'b0, 32'hDEADBEEF, 32'h100, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
      vecs[1]  = '{32'h103, 32'h0,        3'b000, 1'b1, 1'b0, 32'h80FFFFFF, 32'h100, 1'b0, 4'h8, 32'h0,        1'b0, 1'b1, 32'hFFFFFF80};
      vecs[2]  = '{32'h103, 32'h0,        3'b100, 1'b1, 1'b0, 32'h80FFFFFF, 32'h100, 1'b0, 4'h8, 32'h0,        1'b0, 1'b1, 32'h00000080};
      vecs[3]  = '{32'h102, 32'h0,        3'b001, 1'b1, 1'b0, 32'h80011234, 32'h100, 1'b0, 4'hC, 32'h0,        1'b0, 1'b1, 32'hFFFF8001};
      vecs[4]  = '{32'h100, 32'h0,        3'b101, 1'b1, 1'b0, 32'h8001F234, 32'h100, 1'b0, 4'h3, 32'h0,        1'b0, 1'b1, 32'h0000F234};
      vecs[5]  = '{32'h101, 32'h0,        3'b000, 1'b1, 1'b0, 32'h11227F44, 32'h100, 1'b0, 4'h2, 32'h0,        1'b0, 1'b1, 32'h0000007F};
      vecs[6]  = '{32'h202, 32'h1234ABCD, 3'b001, 1'b0, 1'b1, 32'h0,        32'h200, 1'b1, 4'hC, 32'hABCDABCD, 1'b0, 1'b0, 32'h0};
      vecs[7]  = '{32'h301, 32'hAABBCC5A, 3'b000, 1'b0, 1'b1, 32'h0,        32'h300, 1'b1, 4'h2, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h0};
      vecs[8]  = '{32'h404, 32'h0BADF00D, 3'b010, 1'b0, 1'b1, 32'h0,        32'h404, 1'b1, 4'hF, 32'h0BADF00D, 1'b0, 1'b0, 32'h0};
      vecs[9]  = '{32'h408, 32'h13579BDF, 3'b010, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h408, 1'b1, 4'hF, 32'h13579BDF, 1'b0, 1'b0, 32'h0};
      vecs[10] = '{32'h101, 32'h0,        3'b010, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
      vecs[11] = '{32'h003, 32'h0,        3'b001, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
      vecs[12] = '{32'h000, 32'h0,        3'b011, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
      vecs[13] = '{32'h201, 32'h5555AAAA, 3'b001, 1'b0, 1'b1, 32'h0,        32'h0,   1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
      vecs[14] = '{32'h000, 32'h0,        3'b110, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0};

      // Reset.
      rst = 1'b1;
      clear_inputs();
      bus.dmem_req_ready = 1'b0;
      bus.dmem_rsp_valid = 1'b0;
      bus.dmem_rdata     = 32'h0;
      bus.dmem_rsp_err   = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      #1;
      check("rst_state", {30'h0, state_dbg}, 32'h0);
      check("rst_req_valid", {31'h0, bus.dmem_req_valid}, 32'h0);
      check("rst_addr", bus.dmem_addr, 32'h0);
      check("rst_we_be", {27'h0, bus.dmem_we, bus.dmem_be}, 32'h0);
      check("rst_wdata", bus.dmem_wdata, 32'h0);
      check("rst_load_data", load_data_mem, 32'h0);
      check("rst_pulses", {29'h0, load_valid, misaligned, access_fault}, 32'h0);
      check("rst_fault_addr", fault_addr, 32'h0);
      check("rst_stall", {31'h0, mem_stall}, 32'h0);
      step();

      // Table of single accesses.
      for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

      // Ready held low for 5 cycles: payload and stall must hold.
      start_access(32'h500, 32'h0, 3'b010, 1'b1, 1'b0);
      step();
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_req_valid", {31'h0, bus.dmem_req_valid}, 32'h1);
         check("bp_addr", bus.dmem_addr, 32'h500);
         check("bp_be_we", {27'h0, bus.dmem_we, bus.dmem_be}, 32'h0000000F);
         check("bp_stall", {31'h0, mem_stall}, 32'h1);
         step();
      end
      bus.dmem_req_ready = 1'b1;
      step();
      bus.dmem_req_ready = 1'b0;
      bus.dmem_rsp_valid = 1'b1;
      bus.dmem_rdata     = 32'h12345678;
      step();
      bus.dmem_rsp_valid = 1'b0;
      clear_inputs();
      #1;
      check("bp_load_valid", {31'h0, load_valid}, 32'h1);
      check("bp_load_data", load_data_mem, 32'h12345678);
      step();

      // Timeout: no response for 4 WAIT cycles gives an access fault.
      start_access(32'h600, 32'h0, 3'b010, 1'b1, 1'b0);
      step();
      bus.dmem_req_ready = 1'b1;
      step();
      bus.dmem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("to_no_fault_yet", {31'h0, access_fault}, 32'h0);
         check("to_stall", {31'h0, mem_stall}, 32'h1);
         step();
      end
      clear_inputs();
      #1;
      check("to_access_fault", {31'h0, access_fault}, 32'h1);
      check("to_fault_addr", fault_addr, 32'h600);
      check("to_no_load_valid", {31'h0, load_valid}, 32'h0);
      check("to_stall_done", {31'h0, mem_stall}, 32'h0);
      step();

      // Bus error response.
      start_access(32'h700, 32'h0, 3'b010, 1'b1, 1'b0);
      step();
      bus.dmem_req_ready = 1'b1;
      step();
      bus.dmem_req_ready = 1'b0;
      bus.dmem_rsp_valid = 1'b1;
      bus.dmem_rsp_err   = 1'b1;
      bus.dmem_rdata     = 32'hA5A5A5A5;
      step();
      bus.dmem_rsp_valid = 1'b0;
      bus.dmem_rsp_err   = 1'b0;
      clear_inputs();
      #1;
      check("err_access_fault", {31'h0, access_fault}, 32'h1);
      check("err_fault_addr", fault_addr, 32'h700);
      check("err_no_load_valid", {31'h0, load_valid}, 32'h0);
      step();

      // Reset while waiting, then a stale response that must be ignored.
      start_access(32'h800, 32'h0, 3'b010, 1'b1, 1'b0);
      step();
      bus.dmem_req_ready = 1'b1;
      step();
      bus.dmem_req_ready = 1'b0;
      #1;
      check("rw_in_wait", {30'h0, state_dbg}, 32'h2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_inputs();
      bus.dmem_rsp_valid = 1'b1;
      bus.dmem_rdata     = 32'h77777777;
      #1;
      check("rw_state_idle", {30'h0, state_dbg}, 32'h0);
      check("rw_req_valid", {31'h0, bus.dmem_req_valid}, 32'h0);
      check("rw_addr", bus.dmem_addr, 32'h0);
      check("rw_load_data", load_data_mem, 32'h0);
      check("rw_fault_addr", fault_addr, 32'h0);
      check("rw_pulses", {29'h0, load_valid, misaligned, access_fault}, 32'h0);
      check("rw_stall", {31'h0, mem_stall}, 32'h0);
      step();
      bus.dmem_rsp_valid = 1'b0;
      #1;
      check("rw_stale_ignored", {29'h0, load_valid, misaligned, access_fault}, 32'h0);
      check("rw_still_idle", {30'h0, state_dbg}, 32'h0);
      run_vec(99, '{32'h104, 32'h0, 3'b010, 1'b1, 1'b0, 32'hCAFEF00D, 32'h104, 1'b0, 4'hF,
                    32'h0, 1'b0, 1'b1, 32'hCAFEF00D});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
